pc_sequencer: RTL

- Fetch sequencer for the lab CPU. It owns the 9-bit word-addressed program counter and drives fetches to instruction memory over a req/ack handshake.
- It hands each fetched instruction to the decode/execute stage over a valid/ready handshake, then picks the next PC: sequential, or the redirect target on branch/jump.
- It sits between the instruction memory and the controller/datapath. It replaces a free-running PC register.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer_pc_next.sv | 21 ++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the lab CPU fetch path.
// The state enum is shared so checkers and the later pipelined core decode it identically.
package cpu_pkg;
  localparam int PC_W    = 9;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction memory and decode-side handshakes of the fetch sequencer.
// imem: req is held until a one-cycle ack. instr: a transfer happens on any cycle with valid & ready.
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_data, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/pc_sequencer_pc_next.sv
// Next-PC select: hold, redirect target, or sequential increment wrapping at 2^PC_W.
module pc_next
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            hold,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (hold) begin
      next_pc = pc;
    end else if (redirect) begin
      next_pc = redirect_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, fetches one instruction at a time and hands it to decode.
// All outputs come straight from flops; no input reaches an output in the same cycle.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 9'h000,
  parameter int                 TIMEOUT   = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  pc_sequencer_if.master      bus,
  output logic [PC_W-1:0]     pc,
  output logic                halted,
  output logic                err,
  output logic [15:0]         retired,
  output seq_state_t          dbg_state
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [INSTR_W-1:0] instr_q;
  logic               req_q;
  logic [PC_W-1:0]    addr_q;
  logic               valid_q;
  logic [PC_W-1:0]    next_pc;
  logic               is_halt;

  assign is_halt = (instr_q == HALT_WORD);

  pc_next u_pc_next (
    .pc          (pc),
    .hold        (is_halt),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .next_pc     (next_pc)
  );

  // imem_addr is zero whenever no request is outstanding, so it is registered
  // together with imem_req on every transition into or out of FETCH/WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      instr_q  <= '0;
      wait_cnt <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            req_q  <= 1'b1;
            addr_q <= pc;
          end
        end
        ST_FETCH: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_data;
            state   <= ST_ISSUE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            err    <= 1'b1;
            state  <= ST_HALT;
            req_q  <= 1'b0;
            addr_q <= '0;
            halted <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_ISSUE: begin
          if (bus.instr_ready) begin
            retired <= retired + 16'd1;
            pc      <= next_pc;
            valid_q <= 1'b0;
            if (is_halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state  <= ST_FETCH;
              req_q  <= 1'b1;
              addr_q <= next_pc;
            end
          end
        end
        ST_HALT: begin
          if (start) begin
            pc     <= RESET_PC;
            err    <= 1'b0;
            state  <= ST_FETCH;
            halted <= 1'b0;
            req_q  <= 1'b1;
            addr_q <= RESET_PC;
          end
        end
        default: begin
          state   <= ST_IDLE;
          req_q   <= 1'b0;
          addr_q  <= '0;
          valid_q <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign dbg_state       = state;

endmodule
